vexec_ctrl: RTL

- Sequencing controller for the 4-lane, 128-bit vector datapath.
- Accepts one vector instruction at a time from the scalar front end and holds it stable on the datapath.
- Drives operand-mux selects, write-back select and per-lane write enables.
- For unit/strided vector loads and stores, walks active lanes one element per memory transaction and assembles load data into a 128-bit write-back buffer.

---
 rtl/vctrl_pkg.sv | 39 +++
 rtl/vexec_ctrl_if.sv | 21 ++
 rtl/vlane_pick.sv | 29 ++
 rtl/vexec_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vctrl_pkg.sv
// Shared types and encodings for the vector execution controller: FSM states,
// opcode / funct3 constants and operand-mux select encodings.
package vctrl_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  localparam logic [6:0] OP_V  = 7'b1010111;
  localparam logic [6:0] OP_VL = 7'b0000111;
  localparam logic [6:0] OP_VS = 7'b0100111;

  localparam logic [2:0] OPIVV  = 3'b000;
  localparam logic [2:0] OPIVX  = 3'b100;
  localparam logic [2:0] OPIVI  = 3'b011;
  localparam logic [2:0] F3_MEM = 3'b110;

  localparam logic [1:0] OPD1_VS2 = 2'd0;
  localparam logic [1:0] OPD1_VS1 = 2'd1;
  localparam logic [1:0] OPD1_RS1 = 2'd2;

  localparam logic [2:0] OPD2_VS1    = 3'd0;
  localparam logic [2:0] OPD2_VS2    = 3'd1;
  localparam logic [2:0] OPD2_RS1    = 3'd2;
  localparam logic [2:0] OPD2_IMM    = 3'd3;
  localparam logic [2:0] OPD2_OFFSET = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MREQ,
    MWAIT,
    LDWB
  } state_t;

  function automatic logic is_mem_op(input logic [6:0] op, input logic [2:0] f3);
    return ((op == OP_VL) || (op == OP_VS)) && (f3 == F3_MEM);
  endfunction

endpackage

// File: rtl/vexec_ctrl_if.sv
// Element-wide memory request/response channel between the vector controller
// (master) and the data memory (slave).
interface vexec_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/vlane_pick.sv
// Combinational active-lane finder: returns the lowest set mask bit strictly
// above cur (or from lane 0 when from_start is set), plus a none flag.
module vlane_pick
  import vctrl_pkg::*;
(
  input  logic [LANES-1:0]  mask,
  input  logic [LANE_W-1:0] cur,
  input  logic              from_start,
  output logic [LANE_W-1:0] next_lane,
  output logic              none
);

  logic [LANES-1:0] cand;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_cand
    assign cand[gi] = mask[gi] & (from_start | (LANE_W'(gi) > cur));
  end

  // Descending scan so the lowest candidate wins.
  always_comb begin
    next_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (cand[i]) next_lane = LANE_W'(i);
    end
  end

  assign none = ~|cand;

endmodule

// File: rtl/vexec_ctrl.sv
// Sequencing controller for the 4-lane vector datapath: ALU issue plus lane-by-lane
// load/store walking. Optional memory watchdog enabled by VCTRL_TIMEOUT_EN.
module vexec_ctrl
  import vctrl_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 32
`ifdef VCTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [31:0]      inst_in,
  output logic [31:0]      inst,
  input  logic [LANES-1:0] vm,
  input  logic [VLEN-1:0]  valu_out,
  input  logic [VLEN-1:0]  vs3,
  output logic [1:0]       Opd1Sel,
  output logic [2:0]       Opd2Sel,
  output logic             WBSel,
  output logic [LANES-1:0] VWEn,
  output logic [VLEN-1:0]  XDMEM,
  vexec_ctrl_if.master     mem,
  output logic             done,
  output logic             illegal
`ifdef VCTRL_TIMEOUT_EN
  , output logic           err
`endif
);

  state_t            state_reg, state_next;
  logic [31:0]       inst_reg, inst_next;
  logic [LANES-1:0]  lane_en_reg, lane_en_next;
  logic [LANE_W-1:0] lane_reg, lane_next;
  logic              first_reg, first_next;
  logic [VLEN-1:0]   xdmem_reg, xdmem_next;

`ifdef VCTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              err_reg, err_next;
`endif

  logic [ELEN-1:0]   addr_lane  [LANES];
  logic [ELEN-1:0]   wdata_lane [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign addr_lane[gi]  = valu_out[gi*ELEN +: ELEN];
    assign wdata_lane[gi] = vs3[gi*ELEN +: ELEN];
  end

  // The datapath mask is only valid once inst is on the datapath, so the first
  // cycle after accept uses vm directly while it is being captured.
  logic [LANES-1:0]  eff_mask;
  logic [LANE_W-1:0] first_lane, lane_cur, nxt_lane;
  logic              mask_none, nxt_none;

  assign eff_mask = first_reg ? vm : lane_en_reg;

  vlane_pick u_first_pick (
    .mask       (eff_mask),
    .cur        ('0),
    .from_start (1'b1),
    .next_lane  (first_lane),
    .none       (mask_none)
  );

  assign lane_cur = first_reg ? first_lane : lane_reg;

  vlane_pick u_next_pick (
    .mask       (eff_mask),
    .cur        (lane_cur),
    .from_start (1'b0),
    .next_lane  (nxt_lane),
    .none       (nxt_none)
  );

  logic [6:0] in_op, cur_op;
  logic [2:0] in_f3, cur_f3;
  logic       is_store;
  logic       req_c, we_c;

  assign in_op    = inst_in[6:0];
  assign in_f3    = inst_in[14:12];
  assign cur_op   = inst_reg[6:0];
  assign cur_f3   = inst_reg[14:12];
  assign is_store = (cur_op == OP_VS);

  always_comb begin
    state_next   = state_reg;
    inst_next    = inst_reg;
    lane_en_next = first_reg ? vm : lane_en_reg;
    lane_next    = lane_reg;
    first_next   = 1'b0;
    xdmem_next   = xdmem_reg;
    inst_ready   = 1'b0;
    Opd1Sel      = OPD1_VS2;
    Opd2Sel      = OPD2_VS1;
    WBSel        = 1'b0;
    VWEn         = '0;
    req_c        = 1'b0;
    we_c         = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;
`ifdef VCTRL_TIMEOUT_EN
    cnt_next     = '0;
    err_next     = err_reg;
`endif

    unique case (state_reg)
      IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) begin
          if (in_op == OP_V) begin
            inst_next  = inst_in;
            first_next = 1'b1;
            state_next = EXEC;
          end else if (is_mem_op(in_op, in_f3)) begin
            inst_next  = inst_in;
            first_next = 1'b1;
            state_next = MREQ;
          end else begin
            illegal = 1'b1;
          end
        end
      end

      EXEC: begin
        state_next = IDLE;
        if (cur_f3 == OPIVV || cur_f3 == OPIVX || cur_f3 == OPIVI) begin
          Opd2Sel = (cur_f3 == OPIVV) ? OPD2_VS1 :
                    (cur_f3 == OPIVX) ? OPD2_RS1 : OPD2_IMM;
          VWEn    = '1;
          done    = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end

      MREQ: begin
        Opd1Sel   = OPD1_RS1;
        Opd2Sel   = OPD2_OFFSET;
        lane_next = lane_cur;
        if (mask_none) begin
          if (is_store) begin
            done       = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = LDWB;
          end
        end else begin
          req_c = 1'b1;
          we_c  = is_store;
          if (mem.mem_gnt) begin
            if (!is_store) begin
              state_next = MWAIT;
            end else if (nxt_none) begin
              done       = 1'b1;
              state_next = IDLE;
            end else begin
              lane_next = nxt_lane;
            end
          end
        end
      end

      MWAIT: begin
        Opd1Sel = OPD1_RS1;
        Opd2Sel = OPD2_OFFSET;
        if (mem.mem_rvalid) begin
          xdmem_next[lane_reg*ELEN +: ELEN] = mem.mem_rdata;
          if (nxt_none) begin
            state_next = LDWB;
          end else begin
            lane_next  = nxt_lane;
            state_next = MREQ;
          end
        end
      end

      LDWB: begin
        Opd1Sel    = OPD1_RS1;
        Opd2Sel    = OPD2_OFFSET;
        WBSel      = 1'b1;
        VWEn       = lane_en_reg;
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

`ifdef VCTRL_TIMEOUT_EN
    if ((state_reg == MREQ && !mem.mem_gnt) || (state_reg == MWAIT && !mem.mem_rvalid))
      cnt_next = cnt_reg + 1'b1;
    // Watchdog overrides any handshake seen in the expiry cycle.
    if ((state_reg == MREQ || state_reg == MWAIT) && cnt_reg == CNT_W'(TIMEOUT_CYCLES)) begin
      req_c      = 1'b0;
      we_c       = 1'b0;
      done       = 1'b1;
      err_next   = 1'b1;
      cnt_next   = '0;
      lane_next  = lane_reg;
      xdmem_next = xdmem_reg;
      state_next = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      inst_reg    <= '0;
      lane_en_reg <= '0;
      lane_reg    <= '0;
      first_reg   <= 1'b0;
      xdmem_reg   <= '0;
`ifdef VCTRL_TIMEOUT_EN
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      inst_reg    <= inst_next;
      lane_en_reg <= lane_en_next;
      lane_reg    <= lane_next;
      first_reg   <= first_next;
      xdmem_reg   <= xdmem_next;
`ifdef VCTRL_TIMEOUT_EN
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
`endif
    end
  end

  assign inst          = inst_reg;
  assign XDMEM         = xdmem_reg;
  assign mem.mem_req   = req_c;
  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = req_c ? addr_lane[lane_cur] : '0;
  assign mem.mem_wdata = req_c ? wdata_lane[lane_cur] : '0;
`ifdef VCTRL_TIMEOUT_EN
  assign err           = err_reg;
`endif

endmodule
